eater_cpu: RTL and testbench

Parametrised second-generation eater core: an accumulator CPU with a hardwired multi-cycle control FSM, replacing the microcode-ROM sequencer. Data width and RAM depth are generic, and it adds three things the first core lacked: a real halt, a RAM program-load port usable while halted, and a valid/ready output channel with backpressure. It sits between the board-level loader/host and the display/output logic.

---
 rtl/eater_pkg.sv | 48 ++++
 rtl/eater_ram.sv | 32 +++
 rtl/eater_cpu.sv | 190 +++++++++++++++++++
 tb/tb_eater_cpu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eater_pkg.sv
// eater_pkg: shared definitions for the eater_cpu core.
//   - Opcode constants (upper nibble of the instruction word).
//   - FSM state enum for the hardwired control sequencer.
//   - Field-slicing helpers that work for any DATA_W/ADDR_W up to MAX_W.
package eater_pkg;

  // Widest instruction word the slicing helpers accept.
  localparam int MAX_W = 64;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_HALT,
    S_F0,
    S_F1,
    S_F2,
    S_E0,
    S_E1,
    S_E2,
    S_OUTW
  } state_e;

  // Opcode is always the top nibble of a data_w-bit instruction word.
  function automatic logic [3:0] ir_opcode(input logic [MAX_W-1:0] ir, input int data_w);
    return ir[data_w-4 +: 4];
  endfunction

  // Operand field (everything below the opcode), zero-extended.
  function automatic logic [MAX_W-1:0] ir_operand(input logic [MAX_W-1:0] ir, input int data_w);
    return ir & ((MAX_W'(1) << (data_w - 4)) - MAX_W'(1));
  endfunction

  // RAM address: low addr_w bits of the operand.
  function automatic logic [MAX_W-1:0] ir_addr(input logic [MAX_W-1:0] ir, input int addr_w);
    return ir & ((MAX_W'(1) << addr_w) - MAX_W'(1));
  endfunction

endpackage

// File: rtl/eater_ram.sv
// eater_ram: single-port RAM, synchronous write, registered (1-cycle) read.
// Read-before-write on a shared address. Contents are never reset.
// Ports:
//   clk_i     in  clock
//   we_i      in  write enable
//   addr_i    in  ADDR_W word address (shared by read and write)
//   wdata_i   in  DATA_W write data
//   rdata_o   out DATA_W read data, valid one cycle after addr_i
module eater_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/eater_cpu.sv
// eater_cpu: accumulator CPU with a hardwired multi-cycle control FSM.
// Ports:
//   clk_i          in  clock (rising edge)
//   reset_ni       in  asynchronous active-low reset
//   start_i        in  in HALT: restart at address 0
//   halted_o       out core is in HALT
//   load_valid_i   in  RAM program-load write request (honoured only in HALT)
//   load_ready_o   out equals halted_o
//   load_addr_i    in  program-load address
//   load_data_i    in  program-load data
//   out_valid_o    out out_data_o holds an OUT result
//   out_ready_i    in  consumer accepts the OUT result
//   out_data_o     out OUT result
//   pc_o           out program counter (debug)
module eater_cpu
  import eater_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int RUN_ON_RESET = 0
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  output logic              halted_o,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] pc_o
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q;
  logic              c_q;
  logic              z_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;

  logic [3:0]        opcode;
  logic [DATA_W-1:0] operand_ext;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W:0]   alu_sum;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign opcode      = ir_opcode(MAX_W'(ir_q), DATA_W);
  assign operand_ext = DATA_W'(ir_operand(MAX_W'(ir_q), DATA_W));
  assign op_addr     = ADDR_W'(ir_addr(MAX_W'(ir_q), ADDR_W));

  // One extra bit so bit DATA_W is the carry out of ADD and the borrow of SUB.
  always_comb begin
    if (opcode == OP_SUB) begin
      alu_sum = {1'b0, a_q} - {1'b0, ram_rdata};
    end else begin
      alu_sum = {1'b0, a_q} + {1'b0, ram_rdata};
    end
  end

  // The load port owns the RAM while halted; otherwise MAR addresses it and
  // only STA (in E1) writes.
  assign ram_we    = ((state_q == S_HALT) && load_valid_i) ||
                     ((state_q == S_E1) && (opcode == OP_STA));
  assign ram_addr  = (state_q == S_HALT) ? load_addr_i : mar_q;
  assign ram_wdata = (state_q == S_HALT) ? load_data_i : a_q;

  eater_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= (RUN_ON_RESET != 0) ? S_F0 : S_HALT;
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_HALT: begin
          // A and flags are deliberately kept across a restart.
          if (start_i) begin
            pc_q    <= '0;
            state_q <= S_F0;
          end
        end
        S_F0: begin
          mar_q   <= pc_q;
          state_q <= S_F1;
        end
        S_F1: begin
          // RAM read of M[MAR] is in flight this cycle.
          state_q <= S_F2;
        end
        S_F2: begin
          ir_q    <= ram_rdata;
          pc_q    <= pc_q + 1'b1;
          state_q <= S_E0;
        end
        S_E0: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar_q   <= op_addr;
              state_q <= S_E1;
            end
            OP_LDI: begin
              a_q     <= operand_ext;
              state_q <= S_F0;
            end
            OP_JMP: begin
              pc_q    <= op_addr;
              state_q <= S_F0;
            end
            OP_JC: begin
              if (c_q) pc_q <= op_addr;
              state_q <= S_F0;
            end
            OP_JZ: begin
              if (z_q) pc_q <= op_addr;
              state_q <= S_F0;
            end
            OP_OUT: begin
              out_data_q  <= a_q;
              out_valid_q <= 1'b1;
              state_q     <= S_OUTW;
            end
            OP_HLT: begin
              state_q <= S_HALT;
            end
            default: begin
              // NOP and unassigned opcodes 9..D.
              state_q <= S_F0;
            end
          endcase
        end
        S_E1: begin
          // STA's write happens on this edge through ram_we.
          state_q <= (opcode == OP_STA) ? S_F0 : S_E2;
        end
        S_E2: begin
          if (opcode == OP_LDA) begin
            a_q <= ram_rdata;
          end else begin
            a_q <= alu_sum[DATA_W-1:0];
            c_q <= alu_sum[DATA_W];
            z_q <= ~|alu_sum[DATA_W-1:0];
          end
          state_q <= S_F0;
        end
        S_OUTW: begin
          // out_valid_q is always set here, so out_ready_i alone completes it.
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= S_F0;
          end
        end
        default: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign halted_o     = (state_q == S_HALT);
  assign load_ready_o = halted_o;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign pc_o         = pc_q;

endmodule

// File: tb/tb_eater_cpu.sv
// Directed testbench for eater_cpu (DATA_W=8, ADDR_W=4, halt on reset).
module tb_eater_cpu;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       halted;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] pc;

  int total = 0;
  int bad   = 0;

  eater_cpu #(
    .DATA_W(8),
    .ADDR_W(4),
    .RUN_ON_RESET(0)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .start_i     (start),
    .halted_o    (halted),
    .load_valid_i(load_valid),
    .load_ready_o(load_ready),
    .load_addr_i (load_addr),
    .load_data_i (load_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .pc_o        (pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic load_word(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    load_valid = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Returns at the negedge right after the edge that sampled start (edge 0).
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes cycles after edge 0 until HALT; records first OUT and halt edge.
  task automatic run_observe(input int budget, output int oc, output logic [7:0] ov, output int hc);
    oc = -1; ov = 8'h00; hc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (out_valid && oc < 0) begin oc = c; ov = out_data; end
      if (halted) begin hc = c; break; end
    end
    $display("run: out=%02h at edge %0d, halt at edge %0d, pc=%0d", ov, oc, hc, pc);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL reset_halted: got %b want 1", halted); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", pc); end
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL reset_release_halted: got %b want 1", halted); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %02h want 00", out_data); end
    $display("reset: halted=%b load_ready=%b out_valid=%b pc=%0d", halted, load_ready, out_valid, pc);
  endtask

  task automatic test_load_run();
    int oc, hc; logic [7:0] ov;
    out_ready = 1'b1;
    load_word(4'd0, 8'h1E);
    load_word(4'd1, 8'h2F);
    load_word(4'd2, 8'hE0);
    load_word(4'd3, 8'hF0);
    load_word(4'd14, 8'd28);
    // Last load and start on the same edge: both must take effect.
    @(negedge clk);
    load_valid = 1'b1; load_addr = 4'd15; load_data = 8'd14; start = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; start = 1'b0;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL run_started: halted=%b want 0", halted); end
    run_observe(60, oc, ov, hc);
    total++; if (oc !== 16) begin bad++; $display("FAIL run_out_edge: got %0d want 16", oc); end
    total++; if (ov !== 8'd42) begin bad++; $display("FAIL run_out_data: got %0d want 42", ov); end
    total++; if (hc !== 21) begin bad++; $display("FAIL run_halt_edge: got %0d want 21", hc); end
    total++; if (pc !== 4'd4) begin bad++; $display("FAIL run_halt_pc: got %0d want 4", pc); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL run_out_cleared: got %b want 0", out_valid); end
  endtask

  task automatic test_sub_borrow();
    int oc, hc; logic [7:0] ov;
    out_ready = 1'b1;
    load_word(4'd0, 8'h55);   // LDI 5
    load_word(4'd1, 8'h3F);   // SUB [15]
    load_word(4'd2, 8'h78);   // JC 8
    load_word(4'd3, 8'hF0);   // HLT (fall-through)
    load_word(4'd8, 8'hE0);   // OUT
    load_word(4'd9, 8'hF0);   // HLT
    load_word(4'd15, 8'd7);
    start_pulse();
    run_observe(80, oc, ov, hc);
    total++; if (oc !== 18) begin bad++; $display("FAIL borrow_out_edge: got %0d want 18", oc); end
    total++; if (ov !== 8'hFE) begin bad++; $display("FAIL borrow_out_data: got %02h want FE", ov); end
    total++; if (hc !== 23) begin bad++; $display("FAIL borrow_halt_edge: got %0d want 23", hc); end
    total++; if (pc !== 4'd10) begin bad++; $display("FAIL borrow_halt_pc: got %0d want 10", pc); end
  endtask

  task automatic test_jz();
    int oc, hc; logic [7:0] ov;
    out_ready = 1'b1;
    load_word(4'd0, 8'h53);   // LDI 3
    load_word(4'd1, 8'h3F);   // SUB [15]
    load_word(4'd2, 8'h88);   // JZ 8
    load_word(4'd3, 8'h51);   // LDI 1
    load_word(4'd4, 8'hE0);   // OUT
    load_word(4'd5, 8'hF0);   // HLT
    load_word(4'd8, 8'hE0);   // OUT
    load_word(4'd9, 8'hF0);   // HLT
    load_word(4'd15, 8'd3);
    start_pulse();
    run_observe(80, oc, ov, hc);
    total++; if (oc !== 18) begin bad++; $display("FAIL jz_taken_out_edge: got %0d want 18", oc); end
    total++; if (ov !== 8'h00) begin bad++; $display("FAIL jz_taken_out_data: got %02h want 00", ov); end
    total++; if (pc !== 4'd10) begin bad++; $display("FAIL jz_taken_pc: got %0d want 10", pc); end
    load_word(4'd15, 8'd2);
    start_pulse();
    run_observe(80, oc, ov, hc);
    total++; if (oc !== 22) begin bad++; $display("FAIL jz_fall_out_edge: got %0d want 22", oc); end
    total++; if (ov !== 8'h01) begin bad++; $display("FAIL jz_fall_out_data: got %02h want 01", ov); end
    total++; if (hc !== 27) begin bad++; $display("FAIL jz_fall_halt_edge: got %0d want 27", hc); end
    total++; if (pc !== 4'd6) begin bad++; $display("FAIL jz_fall_pc: got %0d want 6", pc); end
  endtask

  task automatic test_backpressure_reset();
    int oc, hc; logic [7:0] ov;
    load_word(4'd0, 8'h1E);
    load_word(4'd1, 8'h2F);
    load_word(4'd2, 8'hE0);
    load_word(4'd3, 8'hF0);
    load_word(4'd14, 8'd28);
    load_word(4'd15, 8'd14);
    out_ready = 1'b0;
    start_pulse();
    oc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin oc = c; break; end
    end
    total++; if (oc !== 16) begin bad++; $display("FAIL bp_out_edge: got %0d want 16", oc); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", k, out_valid); end
      total++; if (out_data !== 8'd42) begin bad++; $display("FAIL bp_data_hold[%0d]: got %0d want 42", k, out_data); end
      total++; if (pc !== 4'd3) begin bad++; $display("FAIL bp_pc_frozen[%0d]: got %0d want 3", k, pc); end
    end
    $display("backpressure: held out_data=%0d pc=%0d for 10 cycles", out_data, pc);
    #2 reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_reset_valid: got %b want 0", out_valid); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL bp_reset_halted: got %b want 1", halted); end
    total++; if (pc !== 4'd0) begin bad++; $display("FAIL bp_reset_pc: got %0d want 0", pc); end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    start_pulse();
    run_observe(60, oc, ov, hc);
    total++; if (ov !== 8'd42) begin bad++; $display("FAIL bp_rerun_data: got %0d want 42", ov); end
    total++; if (hc !== 21) begin bad++; $display("FAIL bp_rerun_halt_edge: got %0d want 21", hc); end
  endtask

  task automatic test_wrap_gating();
    int oc, hc; logic [7:0] ov;
    logic [7:0] prog [16];
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[1]  = 8'h50;   // LDI 0
    prog[2]  = 8'h3E;   // SUB [14] -> A = 0x00 - 0x10 = 0xF0 (HLT)
    prog[3]  = 8'h40;   // STA 0    -> address 0 becomes HLT for the wrap
    prog[14] = 8'h10;   // executed as LDA 0, also the SUB operand
    out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) load_word(4'(i), prog[i]);
    start_pulse();
    hc = -1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL wrap_load_ready_run: got %b want 0", load_ready); end
      end
      // A HLT written to address 4 here would stop the run early if not gated.
      load_valid = (c <= 3); load_addr = 4'd4; load_data = 8'hF0;
      if (halted) begin hc = c; break; end
    end
    load_valid = 1'b0;
    $display("wrap: halt at edge %0d, pc=%0d", hc, pc);
    total++; if (hc !== 73) begin bad++; $display("FAIL wrap_halt_edge: got %0d want 73", hc); end
    total++; if (pc !== 4'd1) begin bad++; $display("FAIL wrap_halt_pc: got %0d want 1", pc); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL wrap_load_ready_halt: got %b want 1", load_ready); end
    start_pulse();
    run_observe(20, oc, ov, hc);
    total++; if (hc !== 4) begin bad++; $display("FAIL wrap_sta_persist: halt edge %0d want 4", hc); end
    total++; if (oc !== -1) begin bad++; $display("FAIL wrap_no_out: out edge %0d want none", oc); end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_addr = '0;
    load_data = '0; out_ready = 1'b1;
    test_reset();
    test_load_run();
    test_sub_borrow();
    test_jz();
    test_backpressure_reset();
    test_wrap_gating();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
